systolic_array: RTL and testbench

- 8x8 weight-stationary systolic matrix-vector engine for the inference datapath.
- Each of the 8 output columns holds 8 signed 8-bit weights, one per input lane.
- Each accepted 64-bit input vector (8 lanes) produces one 64-bit output vector.
- Output lane k is the dot product of the input lanes with column k's weights, in int8 or fp8 mode.

---
 rtl/systolic_array_pkg.sv | 72 +++++++
 rtl/systolic_pe.sv | 39 +++
 rtl/systolic_array.sv | 123 ++++++++++++
 tb/tb_systolic_array.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_array_pkg.sv
// Shared constants, lane types and the fp8 E4M3 multiply-accumulate step for systolic_array.
// The fp8 helper is only referenced when SYSTOLIC_ARRAY_FP8_EN is defined.
package systolic_array_pkg;
   localparam int N          = 8;
   localparam int W          = 8;
   localparam int ACC_W      = 19;
   localparam int LATENCY    = 17;
   localparam int FP8_EXP_W  = 4;
   localparam int FP8_MANT_W = 3;
   localparam int FP8_BIAS   = 7;
   localparam logic [7:0] FP8_POS_MAX = 8'h7F;
   localparam logic [7:0] FP8_NEG_MAX = 8'hFF;
   localparam logic signed [ACC_W-1:0] INT8_MAX = 127;
   localparam logic signed [ACC_W-1:0] INT8_MIN = -128;
   // Exact fixed-point scratch format for one fp8 add: LSB = 2^-FX_FRAC.
   localparam int FX_FRAC = 15;
   localparam int FX_W    = 36;

   typedef logic signed [W-1:0] lane_t;
   typedef lane_t [N-1:0] vec_t;

   typedef struct packed {
      logic                    mode;
      logic signed [ACC_W-1:0] psum;
   } col_t;

   // acc + trunc(a*b), summed exactly then truncated toward zero back to fp8.
   function automatic lane_t fp8_mul_add(input lane_t acc, input lane_t a, input lane_t b);
      logic [7:0]              pm;
      logic [3:0]              psig;
      logic [3:0]              ex;
      logic signed [FX_W-1:0]  fa, fp, fs;
      logic [FX_W-1:0]         mag, nrm;
      int                      ea, eb, eacc, sh, lead;
      lane_t                   res;
      fa   = '0;
      fp   = '0;
      pm   = '0;
      psig = '0;
      ex   = '0;
      nrm  = '0;
      lead = -1;
      ea   = int'(a[FP8_MANT_W +: FP8_EXP_W]);
      eb   = int'(b[FP8_MANT_W +: FP8_EXP_W]);
      eacc = int'(acc[FP8_MANT_W +: FP8_EXP_W]);
      if (eacc != 0) begin
         fa = FX_W'({1'b1, acc[FP8_MANT_W-1:0]}) << (eacc + FX_FRAC - FP8_MANT_W - FP8_BIAS);
         if (acc[W-1]) fa = -fa;
      end
      if (ea != 0 && eb != 0) begin
         pm   = 8'({1'b1, a[FP8_MANT_W-1:0]}) * 8'({1'b1, b[FP8_MANT_W-1:0]});
         psig = pm[7] ? pm[7:4] : pm[6:3];
         sh   = ea + eb - 2*FP8_BIAS + FX_FRAC - FP8_MANT_W + int'(pm[7]);
         fp   = FX_W'(psig) << sh;
         if (a[W-1] ^ b[W-1]) fp = -fp;
      end
      fs  = fa + fp;
      mag = fs[FX_W-1] ? -fs : fs;
      for (int i = 0; i < FX_W; i++)
         if (mag[i]) lead = i;
      if (lead < FX_FRAC + 1 - FP8_BIAS) begin
         res = '0;
      end else if (lead > FX_FRAC + (1 << FP8_EXP_W) - 1 - FP8_BIAS) begin
         res = fs[FX_W-1] ? FP8_NEG_MAX : FP8_POS_MAX;
      end else begin
         nrm = mag >> (lead - FP8_MANT_W);
         ex  = 4'(lead - FX_FRAC + FP8_BIAS);
         res = {fs[FX_W-1], ex, nrm[FP8_MANT_W-1:0]};
      end
      return res;
   endfunction
endpackage

// File: rtl/systolic_pe.sv
// One weight-stationary cell: holds a weight, forwards the input lane right and the psum down.
// fp8 accumulate path is present only with SYSTOLIC_ARRAY_FP8_EN.
module systolic_pe
   import systolic_array_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  lane_t                   load_value,
   input  lane_t                   x_in,
   input  logic                    mode_in,
   input  logic signed [ACC_W-1:0] psum_in,
   output lane_t                   x_out,
   output logic                    mode_out,
   output logic signed [ACC_W-1:0] psum_out
);
   lane_t w;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w        <= '0;
         x_out    <= '0;
         mode_out <= 1'b0;
         psum_out <= '0;
      end else begin
         if (load) w <= load_value;
         x_out    <= x_in;
         mode_out <= mode_in;
`ifdef SYSTOLIC_ARRAY_FP8_EN
         if (mode_in)
            psum_out <= {{(ACC_W-W){1'b0}}, fp8_mul_add(lane_t'(psum_in[W-1:0]), x_in, w)};
         else
            psum_out <= psum_in + ACC_W'(x_in) * ACC_W'(w);
`else
         psum_out <= psum_in + ACC_W'(x_in) * ACC_W'(w);
`endif
      end
   end
endmodule

// File: rtl/systolic_array.sv
// 8x8 weight-stationary matrix-vector engine: input skew, PE grid, output deskew, int8 saturation.
// Define SYSTOLIC_ARRAY_FP8_EN to honour the float input (fp8 E4M3); otherwise everything is int8.
module systolic_array
   import systolic_array_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           float,
   input  logic [N-1:0]   load,
   input  logic [N*W-1:0] input_value,
   input  logic           input_valid,
   output logic           output_valid,
   output logic [N*W-1:0] output_value
);
   logic                    accept;
   vec_t                    in_vec;
   logic                    in_mode;
   logic [LATENCY:0]        vld_pipe;
   lane_t                   x_h  [N][N+1];
   logic                    m_h  [N][N+1];
   logic signed [ACC_W-1:0] ps_v [N+1][N];
   col_t                    col_out [N];
   vec_t                    res;

   // A load cycle owns input_value, so no vector is taken then.
   assign accept       = input_valid && (load == '0);
   assign output_valid = vld_pipe[LATENCY];

`ifndef SYSTOLIC_ARRAY_FP8_EN
   logic unused_float;
   assign unused_float = float;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe     <= '0;
         in_vec       <= '0;
         in_mode      <= 1'b0;
         output_value <= '0;
      end else begin
         vld_pipe <= {vld_pipe[LATENCY-1:0], accept};
         if (accept) begin
            in_vec <= input_value;
`ifdef SYSTOLIC_ARRAY_FP8_EN
            in_mode <= float;
`else
            in_mode <= 1'b0;
`endif
         end
         if (vld_pipe[LATENCY-1]) output_value <= res;
      end
   end

   for (genvar r = 0; r < N; r++) begin : g_row
      if (r == 0) begin : g_noskew
         assign x_h[r][0] = in_vec[r];
         assign m_h[r][0] = in_mode;
      end else begin : g_skew
         lane_t sk_x [r];
         logic  sk_m [r];
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < r; i++) begin
                  sk_x[i] <= '0;
                  sk_m[i] <= 1'b0;
               end
            end else begin
               sk_x[0] <= in_vec[r];
               sk_m[0] <= in_mode;
               for (int i = 1; i < r; i++) begin
                  sk_x[i] <= sk_x[i-1];
                  sk_m[i] <= sk_m[i-1];
               end
            end
         end
         assign x_h[r][0] = sk_x[r-1];
         assign m_h[r][0] = sk_m[r-1];
      end

      for (genvar k = 0; k < N; k++) begin : g_col
         systolic_pe u_pe (
            .clk       (clk),
            .rst       (rst),
            .load      (load[k]),
            .load_value(input_value[W*r +: W]),
            .x_in      (x_h[r][k]),
            .mode_in   (m_h[r][k]),
            .psum_in   (ps_v[r][k]),
            .x_out     (x_h[r][k+1]),
            .mode_out  (m_h[r][k+1]),
            .psum_out  (ps_v[r+1][k])
         );
      end

      logic unused_tail;
      assign unused_tail = ^{x_h[r][N], m_h[r][N]};
   end

   // Column k finishes k cycles after column 0; pad so every lane lands together.
   for (genvar k = 0; k < N; k++) begin : g_deskew
      assign ps_v[0][k] = '0;
      col_t dk [N-k];
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < N-k; i++) dk[i] <= '0;
         end else begin
            dk[0] <= '{mode: m_h[N-1][k+1], psum: ps_v[N][k]};
            for (int i = 1; i < N-k; i++) dk[i] <= dk[i-1];
         end
      end
      assign col_out[k] = dk[N-k-1];
   end

   always_comb begin
      res = '0;
      for (int k = 0; k < N; k++) begin
         if (col_out[k].mode)                       res[k] = col_out[k].psum[W-1:0];
         else if ($signed(col_out[k].psum) > INT8_MAX) res[k] = 8'h7F;
         else if ($signed(col_out[k].psum) < INT8_MIN) res[k] = 8'h80;
         else                                        res[k] = col_out[k].psum[W-1:0];
      end
   end
endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array: directed cases plus a randomized stream vs. a dot-product model.
// fp8 cases are compiled in only when SYSTOLIC_ARRAY_FP8_EN is defined.
module tb_systolic_array;
   logic        clk = 1'b0;
   logic        rst;
   logic        fl;
   logic [7:0]  load;
   logic [63:0] input_value;
   logic        input_valid;
   logic        output_valid;
   logic [63:0] output_value;
   int          checks = 0;
   int          errors = 0;
   logic signed [7:0] wm [8][8];   // wm[column][lane]

   always #5 clk = ~clk;

   systolic_array dut (
      .clk         (clk),
      .rst         (rst),
      .float       (fl),
      .load        (load),
      .input_value (input_value),
      .input_valid (input_valid),
      .output_valid(output_valid),
      .output_value(output_value)
   );

   function automatic logic [63:0] model_int(input logic [63:0] v);
      logic [63:0] r;
      int s;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         s = 0;
         for (int j = 0; j < 8; j++) s += int'($signed(v[8*j +: 8])) * int'(wm[k][j]);
         if (s > 127) s = 127;
         else if (s < -128) s = -128;
         r[8*k +: 8] = 8'(s);
      end
      return r;
   endfunction

`ifdef SYSTOLIC_ARRAY_FP8_EN
   function automatic real pow2(input int e);
      real p = 1.0;
      if (e >= 0) repeat (e) p = p * 2.0;
      else repeat (-e) p = p / 2.0;
      return p;
   endfunction

   function automatic int exp_of(input real m);
      int e = 0;
      while (m >= 2.0) begin m = m / 2.0; e++; end
      while (m < 1.0) begin m = m * 2.0; e--; end
      return e;
   endfunction

   function automatic real fp8_val(input logic [7:0] x);
      if (x[6:3] == 4'd0) return 0.0;
      return (x[7] ? -1.0 : 1.0) * (1.0 + real'(x[2:0]) / 8.0) * pow2(int'(x[6:3]) - 7);
   endfunction

   function automatic real trunc3(input real m);
      int e;
      if (m == 0.0) return 0.0;
      e = exp_of(m);
      return real'($rtoi(m / pow2(e) * 8.0)) / 8.0 * pow2(e);
   endfunction

   function automatic logic [7:0] to_fp8(input real s);
      real m;
      int e;
      m = (s < 0.0) ? -s : s;
      if (m == 0.0) return 8'h00;
      e = exp_of(m);
      if (e > 8) return (s < 0.0) ? 8'hFF : 8'h7F;
      if (e < -6) return 8'h00;
      return {(s < 0.0), 4'(e + 7), 3'($rtoi(m / pow2(e) * 8.0) - 8)};
   endfunction

   function automatic logic [63:0] model_fp8(input logic [63:0] v);
      logic [63:0] r;
      logic [7:0]  acc;
      real a, b, p;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         acc = 8'h00;
         for (int j = 0; j < 8; j++) begin
            a = fp8_val(v[8*j +: 8]);
            b = fp8_val(wm[k][j]);
            p = trunc3((a < 0.0 ? -a : a) * (b < 0.0 ? -b : b));
            if ((a < 0.0) != (b < 0.0)) p = -p;
            acc = to_fp8(fp8_val(acc) + p);
         end
         r[8*k +: 8] = acc;
      end
      return r;
   endfunction
`endif

   function automatic logic [63:0] model_vec(input logic [63:0] v, input logic f);
`ifdef SYSTOLIC_ARRAY_FP8_EN
      if (f) return model_fp8(v);
`endif
      return model_int(v);
   endfunction

   task automatic load_cols(input logic [7:0] mask, input logic [63:0] word);
      @(negedge clk);
      load = mask; input_value = word; input_valid = 1'b0;
      @(negedge clk);
      load = '0;
      for (int k = 0; k < 8; k++)
         if (mask[k]) for (int j = 0; j < 8; j++) wm[k][j] = word[8*j +: 8];
   endtask

   task automatic accept_vec(input logic [63:0] v, input logic f);
      @(negedge clk);
      input_value = v; fl = f; input_valid = 1'b1; load = '0;
      @(posedge clk);
      #1 input_valid = 1'b0;
   endtask

   // Edges until output_valid is seen, -1 if it never comes.
   task automatic wait_valid(output int edges);
      edges = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (output_valid) begin edges = i; return; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; fl = 1'b0; load = '0; input_value = '0; input_valid = 1'b0;
      for (int k = 0; k < 8; k++) for (int j = 0; j < 8; j++) wm[k][j] = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", output_valid); end
      checks++; if (output_value !== 64'h0) begin errors++; $display("FAIL reset_value: got %h want 0", output_value); end
      @(negedge clk) rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", output_valid); end
   endtask

   task automatic test_ones();
      int e;
      load_cols(8'hFF, 64'h0101010101010101);
      accept_vec(64'h0101010101010101, 1'b0);
      wait_valid(e);
      checks++; if (e !== 17) begin errors++; $display("FAIL ones_latency: got %0d edges want 17", e); end
      checks++; if (output_value !== 64'h0808080808080808) begin errors++; $display("FAIL ones_value: got %h want 0808080808080808", output_value); end
      @(posedge clk); #1;
      checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL ones_pulse: got %b want 0", output_valid); end
      checks++; if (output_value !== 64'h0808080808080808) begin errors++; $display("FAIL ones_hold: got %h want 0808080808080808", output_value); end
   endtask

   task automatic test_col_ramp();
      int e;
      for (int k = 0; k < 8; k++) load_cols(8'(1 << k), {8{8'(k + 1)}});
      accept_vec(64'h0101010101010101, 1'b0);
      wait_valid(e);
      checks++; if (e !== 17 || output_value !== 64'h4038302820181008) begin errors++; $display("FAIL col_ramp: got %h after %0d edges want 4038302820181008 after 17", output_value, e); end
   endtask

   task automatic test_identity_and_saturation();
      int e;
      for (int k = 0; k < 8; k++) load_cols(8'(1 << k), 64'h1 << (8 * k));
      accept_vec(64'h0807060504030201, 1'b0);
      wait_valid(e);
      checks++; if (output_value !== 64'h0807060504030201) begin errors++; $display("FAIL identity: got %h want 0807060504030201", output_value); end
      load_cols(8'hFF, 64'h7F7F7F7F7F7F7F7F);
      accept_vec(64'h0202020202020202, 1'b0);
      wait_valid(e);
      checks++; if (output_value !== 64'h7F7F7F7F7F7F7F7F) begin errors++; $display("FAIL sat_pos: got %h want 7F7F7F7F7F7F7F7F", output_value); end
      load_cols(8'hFF, 64'h8080808080808080);
      accept_vec(64'h0101010101010101, 1'b0);
      wait_valid(e);
      checks++; if (output_value !== 64'h8080808080808080) begin errors++; $display("FAIL sat_neg: got %h want 8080808080808080", output_value); end
   endtask

`ifdef SYSTOLIC_ARRAY_FP8_EN
   task automatic test_fp8();
      int e;
      load_cols(8'hFF, 64'h3838383838383838);
      accept_vec(64'h3838383838383838, 1'b1);
      wait_valid(e);
      checks++; if (output_value !== 64'h5050505050505050) begin errors++; $display("FAIL fp8_ones: got %h want 5050505050505050", output_value); end
      accept_vec(64'h0, 1'b1);
      wait_valid(e);
      checks++; if (output_value !== 64'h0) begin errors++; $display("FAIL fp8_zero: got %h want 0", output_value); end
   endtask
`else
   task automatic test_fp8();
      int e;
      load_cols(8'hFF, 64'h3838383838383838);
      accept_vec(64'h3838383838383838, 1'b1);
      wait_valid(e);
      checks++; if (output_value !== 64'h7F7F7F7F7F7F7F7F) begin errors++; $display("FAIL float_ignored: got %h want 7F7F7F7F7F7F7F7F", output_value); end
   endtask
`endif

   task automatic test_random_stream();
      logic [63:0] q[$];
      for (int k = 0; k < 8; k++) load_cols(8'(1 << k), {$urandom, $urandom});
      fork
         begin
            logic [63:0] v;
            for (int i = 0; i < 40; i++) begin
               @(negedge clk);
               v = {$urandom, $urandom};
               input_value = v; fl = 1'($urandom_range(0, 1)); load = '0;
               input_valid = ($urandom_range(0, 3) != 0);
               if (input_valid) q.push_back(model_vec(v, fl));
            end
            @(negedge clk) input_valid = 1'b0;
         end
         begin
            for (int c = 0; c < 70; c++) begin
               @(posedge clk); #1;
               if (output_valid) begin
                  checks++;
                  if (q.size() == 0) begin errors++; $display("FAIL stream_extra: got %h with no vector pending", output_value); end
                  else begin
                     if (output_value !== q[0]) begin errors++; $display("FAIL stream_value: got %h want %h", output_value, q[0]); end
                     void'(q.pop_front());
                  end
               end
            end
         end
      join
      checks++; if (q.size() != 0) begin errors++; $display("FAIL stream_drain: got %0d results missing want 0", q.size()); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] v1, v2, nw, v3, e1, e2;
      int e, extra;
      for (int k = 0; k < 8; k++) load_cols(8'(1 << k), {$urandom, $urandom});
      // Only lane 0 is live, so the column-0 rewrite lands after both vectors used it.
      v1 = {56'h0, 8'($urandom_range(1, 255))};
      v2 = {56'h0, 8'($urandom_range(1, 255))};
      nw = {$urandom, $urandom};
      e1 = model_int(v1);
      e2 = model_int(v2);
      @(negedge clk); input_value = v1; fl = 1'b0; load = '0; input_valid = 1'b1;
      @(negedge clk); input_value = v2;
      @(negedge clk); input_value = nw; load = 8'h01;
      @(negedge clk); load = '0; input_valid = 1'b0;
      for (int j = 0; j < 8; j++) wm[0][j] = nw[8*j +: 8];
      wait_valid(e);
      checks++; if (e !== 15 || output_value !== e1) begin errors++; $display("FAIL b2b_first: got %h after %0d edges want %h after 15", output_value, e, e1); end
      @(posedge clk); #1;
      checks++; if (output_valid !== 1'b1 || output_value !== e2) begin errors++; $display("FAIL b2b_second: got valid %b value %h want 1 %h", output_valid, output_value, e2); end
      extra = 0;
      for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (output_valid) extra++; end
      checks++; if (extra != 0) begin errors++; $display("FAIL b2b_dropped: got %0d extra results want 0", extra); end
      v3 = {$urandom, $urandom};
      accept_vec(v3, 1'b0);
      wait_valid(e);
      checks++; if (output_value !== model_int(v3)) begin errors++; $display("FAIL b2b_newcol: got %h want %h", output_value, model_int(v3)); end
   endtask

   task automatic test_reset_midflight();
      int e, seen;
      logic [63:0] v;
      for (int k = 0; k < 8; k++) load_cols(8'(1 << k), {$urandom, $urandom});
      accept_vec({$urandom, $urandom}, 1'b0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      for (int k = 0; k < 8; k++) for (int j = 0; j < 8; j++) wm[k][j] = '0;
      seen = 0;
      for (int i = 0; i < 25; i++) begin @(posedge clk); #1; if (output_valid) seen++; end
      checks++; if (seen != 0) begin errors++; $display("FAIL rst_drop: got %0d results want 0", seen); end
      checks++; if (output_value !== 64'h0) begin errors++; $display("FAIL rst_value: got %h want 0", output_value); end
      v = {$urandom, $urandom};
      accept_vec(v, 1'b0);
      wait_valid(e);
      checks++; if (e !== 17 || output_value !== model_int(v)) begin errors++; $display("FAIL rst_weights: got %h after %0d edges want %h after 17", output_value, e, model_int(v)); end
   endtask

   initial begin
      test_reset();
      test_ones();
      test_col_ramp();
      test_identity_and_saturation();
      test_fp8();
      test_random_stream();
      test_back_to_back();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
